// File: rtl/cdc_handshake_responder.sv
// Destination-side responder of a 4-phase req/ack crossing: synchronises req_in,
// captures data_in once per handshake and answers with a registered ack level.
module cdc_handshake_responder #(
    parameter int                 WIDTH       = 1,
    parameter int                 SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0]   RESET_VAL   = '0,
    parameter int                 TIMEOUT     = 0,
    parameter int                 CNT_W       = 16
) (
    input  logic             dst_clk,
    input  logic             rst,
    input  logic             req_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             ack_out,
    input  logic             dst_rdy,
    output logic [WIDTH-1:0] dst,
    output logic             dst_val,
    output logic             dst_changed,
    output logic [CNT_W-1:0] xfer_cnt,
    output logic             err_timeout,
    output logic             dbg_state
);

    // Handshake: the initiator raises req_in with data_in stable; we capture once
    // (only when dst_rdy), raise ack_out, and drop it after req_in has fallen.
    typedef enum logic {S_IDLE = 1'b0, S_ACK = 1'b1} state_t;

    localparam int                TMO_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0]  TMO_MAX = TMO_W'(TIMEOUT);

    state_t             state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic               req_s;
    logic               ack_q, ack_d;
    logic [WIDTH-1:0]   dst_q, dst_d;
    logic               val_q, val_d;
    logic               chg_q, chg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;

    assign req_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge dst_clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sync_q  <= '0;
            ack_q   <= 1'b0;
            dst_q   <= RESET_VAL;
            val_q   <= 1'b0;
            chg_q   <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[SYNC_STAGES-2:0], req_in};
            ack_q   <= ack_d;
            dst_q   <= dst_d;
            val_q   <= val_d;
            chg_q   <= chg_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req_s && dst_rdy) state_d = S_ACK;
            S_ACK:   if (!req_s)           state_d = S_IDLE;
            default:                       state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ack_d = ack_q;
        dst_d = dst_q;
        val_d = 1'b0;
        chg_d = 1'b0;
        cnt_d = cnt_q;
        err_d = err_q;
        tmo_d = tmo_q;
        case (state_q)
            S_IDLE: begin
                if (req_s && dst_rdy) begin
                    dst_d = data_in;
                    val_d = 1'b1;
                    chg_d = (data_in != dst_q);
                    cnt_d = cnt_q + 1'b1;
                    ack_d = 1'b1;
                end
            end
            S_ACK: begin
                if (!req_s) begin
                    ack_d = 1'b0;
                    tmo_d = '0;
                end else if (TIMEOUT != 0) begin
                    // Counter saturates at TIMEOUT; the error flag stays until reset.
                    if (tmo_q != TMO_MAX) tmo_d = tmo_q + 1'b1;
                    if (tmo_d == TMO_MAX) err_d = 1'b1;
                end
            end
            default: ack_d = 1'b0;
        endcase
    end

    assign ack_out     = ack_q;
    assign dst         = dst_q;
    assign dst_val     = val_q;
    assign dst_changed = chg_q;
    assign xfer_cnt    = cnt_q;
    assign err_timeout = err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_cdc_handshake_responder.sv
// Directed bench for cdc_handshake_responder acting as the source-side initiator.
module tb_cdc_handshake_responder;

  localparam int WIDTH = 8;
  localparam int SYNC  = 2;
  localparam int CNT_W = 4;
  localparam int TMO   = 8;
  localparam int BOUND = 50;

  logic             dst_clk = 1'b0;
  logic             rst;
  logic             req_in;
  logic [WIDTH-1:0] data_in;
  logic             ack_out;
  logic             dst_rdy;
  logic [WIDTH-1:0] dst;
  logic             dst_val;
  logic             dst_changed;
  logic [CNT_W-1:0] xfer_cnt;
  logic             err_timeout;
  logic             dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int n_pulses = 0;
  logic mon_en = 1'b0;
  logic val_prev = 1'b0;
  logic [WIDTH-1:0] model_dst = '0;
  logic [CNT_W-1:0] model_cnt = '0;
  logic [WIDTH-1:0] exp_q[$];

  cdc_handshake_responder #(
    .WIDTH(WIDTH), .SYNC_STAGES(SYNC), .RESET_VAL(8'h00), .TIMEOUT(TMO), .CNT_W(CNT_W)
  ) dut (
    .dst_clk(dst_clk), .rst(rst), .req_in(req_in), .data_in(data_in),
    .ack_out(ack_out), .dst_rdy(dst_rdy), .dst(dst), .dst_val(dst_val),
    .dst_changed(dst_changed), .xfer_cnt(xfer_cnt), .err_timeout(err_timeout),
    .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 dst_clk = ~dst_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every dst_val pulse pops one expected capture
  always @(negedge dst_clk) begin
    if (rst) begin
      val_prev = 1'b0;
    end else if (mon_en) begin
      if (dst_val) begin
        n_pulses++;
        check("val_width", val_prev, 0);
        if (exp_q.size() == 0) begin
          check("spurious_val", dst_val, 0);
        end else begin
          logic [WIDTH-1:0] e;
          e = exp_q.pop_front();
          check("dst", dst, e);
          check("changed", dst_changed, 32'(e != model_dst));
          model_dst = e;
          model_cnt = model_cnt + 1'b1;
          check("xfer_cnt", xfer_cnt, model_cnt);
        end
      end else begin
        check("dst_hold", dst, model_dst);
        check("changed_idle", dst_changed, 0);
      end
      val_prev = dst_val;
    end
  end

  // driver tasks
  task automatic wait_ack(input logic lvl, output int cyc);
    cyc = 0;
    do begin
      @(negedge dst_clk);
      cyc++;
    end while (ack_out !== lvl && cyc < BOUND);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    model_dst = '0;
    model_cnt = '0;
    @(negedge dst_clk);
    rst = 1'b0;
  endtask

  task automatic xfer(input logic [WIDTH-1:0] d, input string tag);
    int cyc;
    data_in = d;
    req_in  = 1'b1;
    exp_q.push_back(d);
    wait_ack(1'b1, cyc);
    check({tag, "_ack_rise_lat"}, cyc, SYNC + 1);
    req_in = 1'b0;
    wait_ack(1'b0, cyc);
    check({tag, "_ack_fall_lat"}, cyc, SYNC + 1);
  endtask

  initial begin
    int cyc;
    int p0;
    rst = 1'b1; req_in = 1'b0; data_in = '0; dst_rdy = 1'b1;
    repeat (3) @(negedge dst_clk);
    check("rst_ack", ack_out, 0);
    check("rst_dst", dst, 0);
    check("rst_val", dst_val, 0);
    check("rst_chg", dst_changed, 0);
    check("rst_cnt", xfer_cnt, 0);
    check("rst_err", err_timeout, 0);
    check("rst_state", dbg_state, 0);
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge dst_clk);

    // T1 / T2: first capture changes dst, identical second does not
    xfer(8'hA5, "t1");
    check("t1_cnt", xfer_cnt, 1);
    xfer(8'hA5, "t2");
    check("t2_cnt", xfer_cnt, 2);
    xfer(8'h3C, "t2b");

    // T3: stall with dst_rdy low
    p0 = n_pulses;
    dst_rdy = 1'b0;
    data_in = 8'hC3;
    req_in  = 1'b1;
    exp_q.push_back(8'hC3);
    for (int i = 0; i < 10; i++) begin
      @(negedge dst_clk);
      check("t3_stall_ack", ack_out, 0);
    end
    check("t3_stall_pulses", n_pulses, p0);
    dst_rdy = 1'b1;
    wait_ack(1'b1, cyc);
    check("t3_release_lat", cyc, 1);
    req_in = 1'b0;
    wait_ack(1'b0, cyc);
    check("t3_fall_lat", cyc, SYNC + 1);

    // T4: timeout after TMO cycles in ACK with req held
    data_in = 8'h96;
    req_in  = 1'b1;
    exp_q.push_back(8'h96);
    wait_ack(1'b1, cyc);
    check("t4_ack_lat", cyc, SYNC + 1);
    repeat (TMO - 1) @(negedge dst_clk);
    check("t4_err_early", err_timeout, 0);
    @(negedge dst_clk);
    check("t4_err_set", err_timeout, 1);
    check("t4_still_ack", ack_out, 1);
    req_in = 1'b0;
    wait_ack(1'b0, cyc);
    check("t4_fall_lat", cyc, SYNC + 1);
    repeat (3) @(negedge dst_clk);
    check("t4_err_sticky", err_timeout, 1);
    do_reset();
    check("t4_err_clr", err_timeout, 0);

    // T5: reset while in ACK with req still high
    data_in = 8'h5A;
    req_in  = 1'b1;
    exp_q.push_back(8'h5A);
    wait_ack(1'b1, cyc);
    check("t5_ack_lat", cyc, SYNC + 1);
    do_reset();
    check("t5_rst_ack", ack_out, 0);
    check("t5_rst_dst", dst, 0);
    exp_q.push_back(8'h5A);
    wait_ack(1'b1, cyc);
    check("t5_recap_lat", cyc, SYNC + 1);
    check("t5_recap_dst", dst, 8'h5A);
    req_in = 1'b0;
    wait_ack(1'b0, cyc);
    check("t5_fall_lat", cyc, SYNC + 1);

    // T6: 17 handshakes wrap a 4-bit counter
    do_reset();
    p0 = n_pulses;
    for (int i = 0; i < 17; i++) begin
      xfer(8'($urandom_range(0, 255)), "t6");
    end
    repeat (4) @(negedge dst_clk);
    check("t6_pulses", n_pulses - p0, 17);
    check("t6_cnt_wrap", xfer_cnt, 1);
    check("t6_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
